// File: rtl/key_expansion.sv
// key_expansion
//   Sequential AES key schedule generator (FIPS-197 KeyExpansion). The cipher
//   key is captured on an accepted start, then one 32-bit schedule word is
//   computed and written per clock until the whole schedule is present on
//   keyExp. The downstream round-key selector reads keyExp once keyValid is high.
//
// Ports
//   clk       single clock, all state changes on posedge
//   rst       synchronous active-high reset
//   start     expansion request, sampled only in IDLE
//   key       cipher key [0:32*NK-1], word 0 in bits [0:31]
//   busy      high while expanding
//   done      one-cycle pulse when the last word is written
//   keyValid  level, schedule complete and stable
//   keyExp    schedule [0:XW-1], word w[i] in bits [32*i : 32*i+31]
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; keyExp holds the last finished schedule
// EXPAND | writing w[idx] each cycle, idx runs NK .. TOTAL-1

module key_expansion #(
    parameter int NK = 8,
    parameter int NR = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [0:32*NK-1]        key,
    output logic                    busy,
    output logic                    done,
    output logic                    keyValid,
    output logic [0:128*(NR+1)-1]   keyExp
);

    localparam int TOTAL = 4 * (NR + 1);
    localparam int KW    = 32 * NK;
    localparam int XW    = 128 * (NR + 1);
    localparam int IW    = $clog2(TOTAL + 1);
    localparam int PW    = (NK > 1) ? $clog2(NK) : 1;

    localparam logic [IW-1:0] IDX_FIRST = IW'(NK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(TOTAL - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(NK - 1);
    localparam logic [PW-1:0] POS_SUB   = PW'(4);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    // pos tracks idx % NK and rcon tracks Rcon[idx/NK], so no divider is needed.
    logic [PW-1:0] pos;
    logic [7:0]    rcon;

    logic [31:0]   w_prev;
    logic [31:0]   w_back;
    logic [31:0]   w_tmp;
    logic [31:0]   w_new;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        w_prev = '0;
        w_back = '0;
        for (int i = NK; i < TOTAL; i++) begin
            if (idx == i[IW-1:0]) begin
                w_prev = keyExp[32*(i-1) +: 32];
                w_back = keyExp[32*(i-NK) +: 32];
            end
        end

        if (pos == '0) begin
            w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h0};
        end else if ((NK > 6) && (pos == POS_SUB)) begin
            w_tmp = sub_word(w_prev);
        end else begin
            w_tmp = w_prev;
        end

        w_new = w_back ^ w_tmp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            pos      <= '0;
            rcon     <= 8'h01;
            keyExp   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            keyValid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        keyExp   <= {key, {(XW-KW){1'b0}}};
                        idx      <= IDX_FIRST;
                        pos      <= '0;
                        rcon     <= 8'h01;
                        keyValid <= 1'b0;
                        busy     <= 1'b1;
                        state    <= EXPAND;
                    end
                end
                EXPAND: begin
                    for (int i = NK; i < TOTAL; i++) begin
                        if (idx == i[IW-1:0]) begin
                            keyExp[32*i +: 32] <= w_new;
                        end
                    end
                    pos <= (pos == POS_LAST) ? '0 : pos + PW'(1);
                    if (pos == '0) begin
                        rcon <= xtime(rcon);
                    end
                    // idx parks on the last word so it never leaves the schedule range.
                    if (idx == IDX_LAST) begin
                        done     <= 1'b1;
                        keyValid <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion
//   Directed bench for key_expansion: a default AES-256 instance and an AES-128
//   instance. Expected schedules come from a behavioural model using an S-box
//   derived from GF(2^8) inversion; they are queued at start and compared when
//   done pulses. Known FIPS-197 words are also compared directly.

module tb_key_expansion;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            start_a;
    logic [0:255]    key_a;
    logic            busy_a, done_a, kv_a;
    logic [0:1919]   kexp_a;

    logic            start_b;
    logic [0:127]    key_b;
    logic            busy_b, done_b, kv_b;
    logic [0:1407]   kexp_b;

    int tests = 0;
    int fails = 0;

    logic [7:0]    sbt [256];
    logic [7:0]    rcon_t [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [0:1919] q_a [$];
    logic [0:1919] q_b [$];

    localparam logic [0:255] K1 =
        256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    localparam logic [0:127] K2 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

    key_expansion u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .key      (key_a),
        .busy     (busy_a),
        .done     (done_a),
        .keyValid (kv_a),
        .keyExp   (kexp_a)
    );

    key_expansion #(.NK(4), .NR(10)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .key      (key_b),
        .busy     (busy_b),
        .done     (done_b),
        .keyValid (kv_b),
        .keyExp   (kexp_b)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int j = 0; j < 8; j++) begin
            if (b[j]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] t);
        return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
    endfunction

    function automatic logic [0:1919] model(input int nk, input logic [0:255] k);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [0:1919] r;
        int            total;
        total = 4 * (nk + 7);
        r = '0;
        for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0)
                t = sw({t[23:16], t[15:8], t[7:0], t[31:24]}) ^ {rcon_t[i/nk], 24'h0};
            else if (nk > 6 && i % nk == 4)
                t = sw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < total; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkx(input string tag, input logic [0:1919] obs, input logic [0:1919] exp);
        int wi;
        tests++;
        assert (obs === exp) else begin
            fails++;
            wi = 0;
            for (int i = 59; i >= 0; i--)
                if (obs[32*i +: 32] !== exp[32*i +: 32]) wi = i;
            $error("FAIL %s: word %0d observed %h expected %h", tag, wi,
                   obs[32*wi +: 32], exp[32*wi +: 32]);
        end
    endtask

    // Caller is at a negedge; the next posedge accepts the start.
    task automatic launch_a(input logic [0:255] k);
        key_a   = k;
        start_a = 1'b1;
        q_a.push_back(model(8, k));
    endtask

    // mode 0 plain, 1 start pulses (with a different key) while busy,
    // 2 key change while busy, 3 reset at cycle 30. Returns at the done negedge
    // or after the cycle budget.
    task automatic track_a(input string tag, input int mode,
                           output int edges, output int bcnt, output int kvlow);
        logic          got;
        logic [0:1919] exp;
        edges = 0; bcnt = 0; kvlow = 0; got = 1'b0;
        while (!got && edges < 80) begin
            @(negedge clk);
            edges++;
            if (busy_a) bcnt++;
            if (!kv_a) kvlow++;
            if (done_a) begin
                got = 1'b1;
                check32({tag, "_sbq"}, q_a.size(), 1);
                if (q_a.size() > 0) begin
                    exp = q_a.pop_front();
                    checkx({tag, "_sched"}, kexp_a, exp);
                end
            end
            if (edges == 1 || edges == 6 || edges == 21) start_a = 1'b0;
            if (mode == 1 && (edges == 5 || edges == 20)) begin
                start_a = 1'b1;
                key_a   = ~key_a;
            end
            if (mode == 2 && edges == 10) key_a = {8{32'hdeadbeef}};
            if (mode == 3 && edges == 30) rst = 1'b1;
            if (mode == 3 && edges == 31) begin
                checkx({tag, "_rst_kexp"}, kexp_a, '0);
                check32({tag, "_rst_busy"}, busy_a, 0);
                check32({tag, "_rst_kv"}, kv_a, 0);
                check32({tag, "_rst_done"}, done_a, 0);
                rst = 1'b0;
                q_a.delete();
            end
        end
    endtask

    task automatic track_b(input string tag, output int edges, output int bcnt);
        logic          got;
        logic [0:1919] exp;
        edges = 0; bcnt = 0; got = 1'b0;
        while (!got && edges < 80) begin
            @(negedge clk);
            edges++;
            if (edges == 1) start_b = 1'b0;
            if (busy_b) bcnt++;
            if (done_b) begin
                got = 1'b1;
                check32({tag, "_sbq"}, q_b.size(), 1);
                if (q_b.size() > 0) begin
                    exp = q_b.pop_front();
                    checkx({tag, "_sched"}, {kexp_b, 512'h0}, exp);
                end
            end
        end
    endtask

    initial begin
        int e, b, kl;
        logic [7:0]   inv;
        logic [0:255] rk;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; key_a = '0; key_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check32("reset_busy", busy_a, 0);
        check32("reset_done", done_a, 0);
        check32("reset_kv", kv_a, 0);
        checkx("reset_kexp", kexp_a, '0);
        check32("reset_b_busy", busy_b, 0);
        check32("reset_b_kv", kv_b, 0);

        // AES-256 reference key
        launch_a(K1);
        track_a("t1", 0, e, b, kl);
        check32("t1_latency", e, 53);
        check32("t1_busy_cycles", b, 52);
        check32("t1_kv_low", kl, 52);
        check32("t1_w8", kexp_a[32*8 +: 32], 32'h9ba35411);
        check32("t1_w12", kexp_a[32*12 +: 32], 32'ha8b09c1a);
        check32("t1_w59", kexp_a[32*59 +: 32], 32'h706c631e);
        @(negedge clk);
        check32("t1_done_one_cycle", done_a, 0);
        check32("t1_kv_held", kv_a, 1);
        check32("t1_busy_idle", busy_a, 0);

        // AES-128 reference key
        key_b = K2; start_b = 1'b1;
        q_b.push_back(model(4, {K2, 128'h0}));
        track_b("t2", e, b);
        check32("t2_latency", e, 41);
        check32("t2_busy_cycles", b, 40);
        check32("t2_w4", kexp_b[32*4 +: 32], 32'ha0fafe17);
        check32("t2_w43", kexp_b[32*43 +: 32], 32'hb6630ca6);

        // start pulses while busy are ignored
        @(negedge clk);
        launch_a(K1);
        track_a("t3", 1, e, b, kl);
        check32("t3_latency", e, 53);
        check32("t3_w59", kexp_a[32*59 +: 32], 32'h706c631e);
        @(negedge clk);
        check32("t3_single_done", done_a, 0);
        check32("t3_no_restart", busy_a, 0);

        // key input changed mid-expansion
        launch_a(K1);
        track_a("t6", 2, e, b, kl);
        check32("t6_latency", e, 53);
        check32("t6_w12", kexp_a[32*12 +: 32], 32'ha8b09c1a);

        // reset mid-expansion, then a fresh run
        @(negedge clk);
        launch_a(K1);
        track_a("t4", 3, e, b, kl);
        check32("t4_no_done", e, 80);
        launch_a(K1);
        track_a("t4_fresh", 0, e, b, kl);
        check32("t4_fresh_latency", e, 53);
        check32("t4_fresh_w8", kexp_a[32*8 +: 32], 32'h9ba35411);

        // start accepted in the done cycle, zero key
        launch_a('0);
        track_a("t5", 0, e, b, kl);
        check32("t5_latency", e, 53);
        check32("t5_kv_low", kl, 52);
        check32("t5_w8", kexp_a[32*8 +: 32], 32'h62636363);

        // random keys back to back
        for (int n = 0; n < 2; n++) begin
            for (int j = 0; j < 8; j++) rk[32*j +: 32] = $urandom();
            launch_a(rk);
            track_a("rand", 0, e, b, kl);
            check32("rand_latency", e, 53);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
